// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory-timeout fault.
// Optional single-step debug state is compiled in with `MC_SEQ_STEP_EN.
module mc_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        mem_ack,
`ifdef MC_SEQ_STEP_EN
  input  logic        step_req,
`endif
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_we,
  output logic        ab_we,
  output logic        alu_we,
  output logic        mdr_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [2:0]  state,
  output logic [31:0] instr_cnt,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_STEP   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] CLS_COMMIT = 2'd0;
  localparam logic [1:0] CLS_WB     = 2'd1;
  localparam logic [1:0] CLS_MEM    = 2'd2;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  state_t      commit_next;
  logic [7:0]  tmo_cnt;
  logic        mem_busy;
  logic        tmo_hit;

  // Where an instruction goes after EXEC; anything unrecognised retires there.
  function automatic logic [1:0] exec_class(input logic [5:0] o, input logic [5:0] f);
    logic [1:0] c;
    c = CLS_COMMIT;
    if (o == OP_RTYPE)               c = (f == FN_JR) ? CLS_COMMIT : CLS_WB;
    else if (o[5:3] == 3'b001)       c = CLS_WB;
    else if (o == OP_LW || o == OP_SW) c = CLS_MEM;
    else if (o == OP_JAL)            c = CLS_WB;
    return c;
  endfunction

  assign state    = state_q;
  assign mem_busy = (state_q == S_FETCH) || (state_q == S_MEM);
  assign tmo_hit  = mem_busy && !mem_ack && (tmo_cnt == TMO_LAST);

`ifdef MC_SEQ_STEP_EN
  assign commit_next = S_STEP;
`else
  assign commit_next = run ? S_FETCH : S_IDLE;
`endif

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    mem_sel = 1'b0;
    ir_we   = 1'b0;
    ab_we   = 1'b0;
    alu_we  = 1'b0;
    mdr_we  = 1'b0;
    rf_we   = 1'b0;
    pc_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run && !timeout_err) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
        if (mem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        ab_we   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_we = 1'b1;
        case (exec_class(op, func))
          CLS_WB:  state_d = S_WB;
          CLS_MEM: state_d = S_MEM;
          default: pc_we = 1'b1;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (op == OP_SW);
        if (mem_ack) begin
          if (op == OP_SW) begin
            pc_we = 1'b1;
          end else begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
      end
`ifdef MC_SEQ_STEP_EN
      S_STEP: begin
        if (step_req) state_d = run ? S_FETCH : S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (pc_we)   state_d = commit_next;
    // A stuck memory abandons the instruction without retiring it.
    if (tmo_hit) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tmo_cnt     <= 8'd0;
      timeout_err <= 1'b0;
      instr_cnt   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (!mem_busy || mem_ack) tmo_cnt <= 8'd0;
      else                      tmo_cnt <= tmo_cnt + 8'd1;
      if (tmo_hit) timeout_err <= 1'b1;
      if (pc_we)   instr_cnt <= instr_cnt + 32'd1;
    end
  end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle control sequencer for the MIPS core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, so the existing decode/ALU/register-file datapath and a single shared instruction/data memory can run over several cycles instead of one. It drives every datapath latch enable and the memory request handshake. It also retires instructions, watches memory latency, and optionally supports single-step debug.

## Interface
- MEM_TIMEOUT, 15: cycles `mem_req` may stay high without `mem_ack` before a timeout fault is raised (range 1..255).
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; enables leaving IDLE and continuing after each commit.
- op  in  6  instruction bits [31:26], taken from the instruction register; valid from DECODE onward.
- func  in  6  instruction bits [5:0], taken from the instruction register.
- mem_ack  in  1  memory has completed the current request (read data valid / write done).
- mem_req  out  1  memory request.
- mem_we  out  1  write qualifier for `mem_req`.
- mem_sel  out  1  memory address source: 0 = PC, 1 = ALU-computed data address.
- ir_we  out  1  load the instruction register.
- ab_we  out  1  latch `rdata1`/`rdata2` into the A/B operand registers.
- alu_we  out  1  latch the ALU result register.
- mdr_we  out  1  latch memory read data into the MDR.
- rf_we  out  1  register-file write enable.
- pc_we  out  1  commit `pc_out` to the PC; pulses exactly once per instruction.
- state  out  3  current state encoding.
- instr_cnt  out  32  count of retired instructions.
- timeout_err  out  1  sticky memory-timeout fault.
- step_req  in  1  single-step pulse; this port exists only with `MC_SEQ_STEP_EN`.

## Operation
- **State encodings:** IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, STEP=6. Encoding 7 is illegal and goes to IDLE.
- **IDLE:** all enables are 0. Go to FETCH when `run`=1 and `timeout_err`=0.
- **FETCH:**
  - `mem_req`=1, `mem_sel`=0, `mem_we`=0.
  - `ir_we` = `mem_ack`.
  - Advance to DECODE on `mem_ack`.
- **DECODE:** `ab_we`=1; always go to EXEC.
- **EXEC:** `alu_we`=1. Next state by instruction class:
  - R-type with `func` ≠ jr (001000), or an I-type ALU op (001000–001111): go to WB.
  - lw (100011) or sw (101011): go to MEM.
  - jal (000011): go to WB.
  - jr, j (000010), beq (000100), bne (000101), or any undefined op: `pc_we`=1 in EXEC (commit).
- **MEM:**
  - `mem_req`=1, `mem_sel`=1, `mem_we` = (op == sw).
  - On `mem_ack`: for lw, `mdr_we`=1 and go to WB; for sw, `pc_we`=1 (commit).
- **WB:** `rf_we`=1, `pc_we`=1 (commit).
- **Commit:**
  - `instr_cnt` increments by 1 and wraps from 0xFFFFFFFF to 0.
  - Next state is FETCH if `run`=1, otherwise IDLE.
  - A deasserted `run` mid-instruction never aborts; the instruction always completes.
- **Timeout:**
  - An 8-bit counter clears whenever `mem_req` is 0 or `mem_ack` is 1, and increments on each cycle with `mem_req`=1 and `mem_ack`=0.
  - When it reaches MEM_TIMEOUT, `timeout_err` is set, the state goes to IDLE, and `mem_req` drops on the next cycle.
  - No commit occurs and `instr_cnt` is unchanged.
  - Only `rst_n` clears `timeout_err`.
- All enable outputs are combinational from `state`, `op`, `func` and `mem_ack`. No enable other than `mem_req`/`mem_we`/`mem_sel` is ever high in IDLE or STEP.

## Timing
- **Reset:** while `rst_n`=0, `state`=IDLE, all enables are 0, `instr_cnt`=0, `timeout_err`=0, and the timeout counter is 0. An asserted reset in the middle of an instruction drops `mem_req` immediately (asynchronously).
- **Handshake:**
  - `mem_req` stays high until the cycle in which `mem_ack` is sampled high.
  - A zero-wait ack (in the first request cycle) is legal.
  - `mem_req` is low for at least one cycle between FETCH and MEM.
  - `mem_ack` while `mem_req`=0 is ignored.
- **Cycles per instruction with zero-wait memory:**
  - Branch/jump/jr/undefined: 3.
  - R-type, I-type ALU, jal, sw: 4.
  - lw: 5.
  - Each wait cycle adds 1.
- **Run from IDLE:** `run` rising in IDLE gives FETCH on the following edge.

## Configuration
- **`MC_SEQ_STEP_EN` defined:**
  - Every commit goes to STEP instead of FETCH/IDLE.
  - STEP holds all enables at 0 and waits.
  - A `step_req`=1 sample moves to FETCH, but only if `run`=1; otherwise STEP moves to IDLE.
  - `step_req` is ignored in all other states.
- **Not defined:** the `step_req` port and the STEP state are absent, and encoding 6 is illegal (goes to IDLE).

## Test plan
- Reset asserted mid-MEM → `state`=0, `mem_req`=0 and `instr_cnt`=0 asynchronously. Release with `run`=1 → FETCH on the next edge.
- `add` (op 0, func 100000), zero-wait → states 1,2,3,5; `rf_we` and `pc_we` high only in WB; `instr_cnt` goes 0→1 after 4 cycles.
- lw with `mem_ack` delayed 2 cycles in MEM → states 1,2,3,4,4,4,5; `mdr_we` only in the ack cycle; 7 cycles total.
- beq followed by sw, zero-wait → beq `pc_we` in EXEC (3 cycles); sw MEM cycle has `mem_we`=1 and `mem_sel`=1; no `rf_we` in either instruction.
- `mem_ack` held 0 in FETCH with MEM_TIMEOUT=15 → `timeout_err`=1 after 15 request cycles; `state`=IDLE; `run`=1 no longer leaves IDLE.
- `MC_SEQ_STEP_EN` defined, addi → after WB `state`=6 and holds; `step_req` pulse → FETCH on the next edge.
